instr_line_fetch: RTL

//  Initiator for the instruction port of the dual-port RAM wrapper (req/gnt/rvalid, 128-bit lines).

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/fetch_line_fifo.sv | 51 +++++
 rtl/instr_line_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction line fetch unit.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package instr_fetch_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;

    typedef logic [127:0] line_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    // Extract 32-bit word idx from a 128-bit line (word k in bits [32k+31:32k])
    function automatic logic [31:0] line_word(input line_t line, input logic [1:0] idx);
        return line[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/fetch_line_fifo.sv
// Line buffer: DEPTH entries of {line address, 128-bit line}, push/pop/flush.
// Latency: pushed entry visible at head the cycle after push; head is a combinational read.
// Backpressure: none internally; caller guarantees no push when full, flush wins over push/pop.
module fetch_line_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 150
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;

    // Entry storage; no reset needed since count gates visibility of the contents
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_line_fetch.sv
// Fetches 128-bit lines from the RAM instruction port and streams 32-bit instructions out.
// Latency: redirect at T -> request T+1 -> out_valid_o T+3 with a single-cycle RAM.
// Backpressure: out_ready_i low stalls the word stream; requests stop once buffered+in-flight lines reach LINE_DEPTH.
module instr_line_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 22,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int                    LINE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_req_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  line_t                 instr_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_instr_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o
);

    localparam int CW  = $clog2(LINE_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int EW  = ADDR_WIDTH + 128;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] LINE_INC  = ADDR_WIDTH'(LINE_BYTES);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, nxt_line_q, rsp_line_q, pc_q;
    logic [ADDR_WIDTH-1:0] branch_line, base_line, head_addr;
    logic [CW-1:0]         outst_q, outst_d, disc_q, disc_d, occ_q, occ_d;
    logic [1:0]            w_q;
    logic                  grant, held, launch, rule;
    logic                  fifo_push, fifo_pop, handshake;
    logic [EW-1:0]         head_dat;
    line_t                 head_line;

    assign branch_line = branch_addr_i & LINE_MASK;
    assign grant       = (state_q == REQ) && instr_gnt_i;
    assign held        = (state_q == REQ) && !instr_gnt_i;
    assign handshake   = out_valid_o && out_ready_i && !branch_i;
    assign fifo_pop    = handshake && (w_q == 2'd3);
    assign fifo_push   = instr_rvalid_i && !branch_i && (disc_q == '0);
    assign base_line   = branch_i ? branch_line : nxt_line_q;

    // Next-cycle accounting: in-flight lines, lines to drop, buffer occupancy, request rule
    always_comb begin
        outst_d = outst_q + CW'(grant) - CW'(instr_rvalid_i);
        occ_d   = branch_i ? '0 : (occ_q + CW'(fifo_push) - CW'(fifo_pop));
        rule    = fetch_en_i && ((CW1'(outst_d) + CW1'(occ_d)) < CW1'(LINE_DEPTH));
        disc_d  = disc_q;
        if (branch_i) begin
            // everything already granted, plus a still-held request, belongs to the old stream
            disc_d = outst_d + CW'(held);
        end else if (instr_rvalid_i && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end
    end

    // Request FSM next state; a raised request is never withdrawn before its grant
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rule) begin
                    state_d = REQ;
                    launch  = 1'b1;
                end
            end
            REQ: begin
                if (instr_gnt_i) begin
                    if (rule) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request address and next line to request; a redirect retargets only unlaunched lines
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q <= BOOT_ADDR & LINE_MASK;
            nxt_line_q <= BOOT_ADDR & LINE_MASK;
        end else if (launch) begin
            req_addr_q <= base_line;
            nxt_line_q <= base_line + LINE_INC;
        end else if (branch_i) begin
            nxt_line_q <= branch_line;
        end
    end

    // In-flight and discard counters
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q <= '0;
            disc_q  <= '0;
        end else begin
            outst_q <= outst_d;
            disc_q  <= disc_d;
        end
    end

    // Word index, address tag of the next kept response, and idle output address
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= BOOT_ADDR[3:2];
            rsp_line_q <= BOOT_ADDR & LINE_MASK;
            pc_q       <= BOOT_ADDR;
        end else if (branch_i) begin
            w_q        <= branch_addr_i[3:2];
            rsp_line_q <= branch_line;
            pc_q       <= branch_addr_i & WORD_MASK;
        end else begin
            if (fifo_push) begin
                rsp_line_q <= rsp_line_q + LINE_INC;
            end
            if (handshake) begin
                w_q  <= w_q + 2'd1;
                pc_q <= out_addr_o + ADDR_WIDTH'(4);
            end
        end
    end

    fetch_line_fifo #(
        .DEPTH (LINE_DEPTH),
        .WIDTH (EW)
    ) u_line_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({rsp_line_q, instr_rdata_i}),
        .pop      (fifo_pop),
        .flush    (branch_i),
        .head_dat (head_dat),
        .count    (occ_q)
    );

    assign head_line    = head_dat[127:0];
    assign head_addr    = head_dat[EW-1:128];
    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = req_addr_q;
    assign out_valid_o  = (occ_q != '0);
    assign out_instr_o  = out_valid_o ? line_word(head_line, w_q) : 32'd0;
    assign out_addr_o   = out_valid_o ? (head_addr | ADDR_WIDTH'({w_q, 2'b00})) : pc_q;

    a_rvalid_has_outstanding: assert property (@(posedge clk) disable iff (rst)
        instr_rvalid_i |-> (outst_q != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        fifo_push |-> (occ_q != CW'(LINE_DEPTH)));

endmodule
